// File: rtl/tag_issuer_wide_if.sv
// Decode-to-dispatch rename bundle, free-pool feed and commit port for tag_issuer_wide.
// The master drives bundles, pool tags, commits and flush; the slave is the issuer.
interface tag_issuer_wide_if #(
    parameter int TAG_W    = 6,
    parameter int EMBEDDED = 1,
    parameter int LANES    = 2
);
    localparam int ADDR_W = EMBEDDED ? 4 : 5;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          in_lane_valid;
    logic [LANES*ADDR_W-1:0]   in_rs1;
    logic [LANES*ADDR_W-1:0]   in_rs2;
    logic [LANES*ADDR_W-1:0]   in_rd;
    logic [LANES-1:0]          in_rs1_en;
    logic [LANES-1:0]          in_rs2_en;
    logic [LANES-1:0]          in_rd_en;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES-1:0]          out_lane_valid;
    logic [LANES*TAG_W-1:0]    out_rs1_tag;
    logic [LANES*TAG_W-1:0]    out_rs2_tag;
    logic [LANES-1:0]          out_rs1_pend;
    logic [LANES-1:0]          out_rs2_pend;
    logic [LANES*TAG_W-1:0]    out_rd_tag;
    logic [LANES-1:0]          out_rd_valid;
    logic                      pool_valid;
    logic [TAG_W-1:0]          pool_tag;
    logic                      pool_ready;
    logic                      commit_valid;
    logic [ADDR_W-1:0]         commit_addr;
    logic [TAG_W-1:0]          commit_tag;

    modport master (
        output flush, in_valid, in_lane_valid, in_rs1, in_rs2, in_rd,
               in_rs1_en, in_rs2_en, in_rd_en, out_ready,
               pool_valid, pool_tag, commit_valid, commit_addr, commit_tag,
        input  in_ready, out_valid, out_lane_valid, out_rs1_tag, out_rs2_tag,
               out_rs1_pend, out_rs2_pend, out_rd_tag, out_rd_valid, pool_ready
    );

    modport slave (
        input  flush, in_valid, in_lane_valid, in_rs1, in_rs2, in_rd,
               in_rs1_en, in_rs2_en, in_rd_en, out_ready,
               pool_valid, pool_tag, commit_valid, commit_addr, commit_tag,
        output in_ready, out_valid, out_lane_valid, out_rs1_tag, out_rs2_tag,
               out_rs1_pend, out_rs2_pend, out_rd_tag, out_rd_valid, pool_ready
    );
endinterface

// File: rtl/tag_issuer_wide.sv
// Multi-lane register renamer: hot-tag table, fresh-tag prefetch FIFO, intra-bundle
// bypass and a single registered output stage.
module tag_issuer_wide #(
    parameter int TAG_W          = 6,
    parameter int EMBEDDED       = 1,
    parameter int LANES          = 2,
    parameter int PREFETCH_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    tag_issuer_wide_if.slave bus
);
    localparam int ADDR_W = EMBEDDED ? 4 : 5;
    localparam int NREG   = 1 << ADDR_W;
    localparam int PTR_W  = $clog2(PREFETCH_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [TAG_W-1:0]       r_fifo [PREFETCH_DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;

    logic [NREG-1:0]        r_tbl_vld;
    logic [TAG_W-1:0]       r_tbl_tag [NREG];

    logic                   r_vld_p1;
    logic [LANES-1:0]       r_lane_vld_p1;
    logic [LANES*TAG_W-1:0] r_rs1_tag_p1;
    logic [LANES*TAG_W-1:0] r_rs2_tag_p1;
    logic [LANES-1:0]       r_rs1_pend_p1;
    logic [LANES-1:0]       r_rs2_pend_p1;
    logic [LANES*TAG_W-1:0] r_rd_tag_p1;
    logic [LANES-1:0]       r_rd_vld_p1;

    logic [ADDR_W-1:0]      w_rd [LANES];
    logic [TAG_W-1:0]       w_fresh [LANES];
    logic [LANES-1:0]       w_need_lane;
    logic [CNT_W-1:0]       w_need;
    logic [CNT_W-1:0]       w_pop;
    logic                   w_push;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_commit_hit;
    logic [LANES*TAG_W-1:0] w_rs1_tag;
    logic [LANES*TAG_W-1:0] w_rs2_tag;
    logic [LANES-1:0]       w_rs1_pend;
    logic [LANES-1:0]       w_rs2_pend;
    logic [LANES*TAG_W-1:0] w_rd_tag;

    // Needing lanes take consecutive FIFO entries from the head in lane order.
    always_comb begin
        logic [CNT_W-1:0] v_cnt;
        logic [PTR_W-1:0] v_idx;
        v_cnt       = '0;
        v_idx       = '0;
        w_need_lane = '0;
        w_rd_tag    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_rd[k]        = bus.in_rd[k*ADDR_W +: ADDR_W];
            w_need_lane[k] = bus.in_lane_valid[k] & bus.in_rd_en[k] & (w_rd[k] != '0);
            v_idx          = r_rd_ptr + v_cnt[PTR_W-1:0];
            w_fresh[k]     = w_need_lane[k] ? r_fifo[v_idx] : '0;
            w_rd_tag[k*TAG_W +: TAG_W] = w_fresh[k];
            v_cnt          = v_cnt + CNT_W'(w_need_lane[k]);
        end
        w_need = v_cnt;
    end

    assign w_push       = bus.pool_valid & bus.pool_ready;
    assign w_in_ready   = ~bus.flush & (~r_vld_p1 | bus.out_ready) & (r_count >= w_need);
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_pop        = w_accept ? w_need : '0;
    assign w_commit_hit = bus.commit_valid & r_tbl_vld[bus.commit_addr]
                        & (r_tbl_tag[bus.commit_addr] == bus.commit_tag);

    // Returns {pend, tag}; the youngest lower-lane producer beats the table.
    function automatic logic [TAG_W:0] resolve(input logic [ADDR_W-1:0] a,
                                               input logic en, input int k);
        logic [TAG_W:0] res;
        res = '0;
        if (en && (a != '0)) begin
            res = {r_tbl_vld[a] & ~(w_commit_hit & (a == bus.commit_addr)), r_tbl_tag[a]};
            for (int j = 0; j < LANES; j++) begin
                if ((j < k) && w_need_lane[j] && (w_rd[j] == a))
                    res = {1'b1, w_fresh[j]};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rs1_tag  = '0;
        w_rs2_tag  = '0;
        w_rs1_pend = '0;
        w_rs2_pend = '0;
        for (int k = 0; k < LANES; k++) begin
            {w_rs1_pend[k], w_rs1_tag[k*TAG_W +: TAG_W]} =
                resolve(bus.in_rs1[k*ADDR_W +: ADDR_W], bus.in_rs1_en[k], k);
            {w_rs2_pend[k], w_rs2_tag[k*TAG_W +: TAG_W]} =
                resolve(bus.in_rs2[k*ADDR_W +: ADDR_W], bus.in_rs2_en[k], k);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.pool_tag;
    end

    // Flush leaves the prefetched tags in place; only reset drops them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push) - w_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tbl_vld <= '0;
            for (int i = 0; i < NREG; i++) r_tbl_tag[i] <= '0;
        end else if (bus.flush) begin
            r_tbl_vld <= '0;
        end else begin
            if (w_commit_hit) r_tbl_vld[bus.commit_addr] <= 1'b0;
            if (w_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_need_lane[k]) begin
                        r_tbl_vld[w_rd[k]] <= 1'b1;
                        r_tbl_tag[w_rd[k]] <= w_fresh[k];
                    end
                end
            end
        end
    end

    // Output stage boundary: p1 holds the renamed bundle until dispatch accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1      <= 1'b0;
            r_lane_vld_p1 <= '0;
            r_rs1_tag_p1  <= '0;
            r_rs2_tag_p1  <= '0;
            r_rs1_pend_p1 <= '0;
            r_rs2_pend_p1 <= '0;
            r_rd_tag_p1   <= '0;
            r_rd_vld_p1   <= '0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1      <= 1'b1;
            r_lane_vld_p1 <= bus.in_lane_valid;
            r_rs1_tag_p1  <= w_rs1_tag;
            r_rs2_tag_p1  <= w_rs2_tag;
            r_rs1_pend_p1 <= w_rs1_pend;
            r_rs2_pend_p1 <= w_rs2_pend;
            r_rd_tag_p1   <= w_rd_tag;
            r_rd_vld_p1   <= w_need_lane;
        end else if (bus.out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.pool_ready     = (r_count != CNT_W'(PREFETCH_DEPTH));
    assign bus.out_valid      = r_vld_p1;
    assign bus.out_lane_valid = r_lane_vld_p1;
    assign bus.out_rs1_tag    = r_rs1_tag_p1;
    assign bus.out_rs2_tag    = r_rs2_tag_p1;
    assign bus.out_rs1_pend   = r_rs1_pend_p1;
    assign bus.out_rs2_pend   = r_rs2_pend_p1;
    assign bus.out_rd_tag     = r_rd_tag_p1;
    assign bus.out_rd_valid   = r_rd_vld_p1;
endmodule

// File: tb/tb_tag_issuer_wide.sv
// Directed scoreboard bench for tag_issuer_wide with two lanes, 16 registers, depth 4.
module tb_tag_issuer_wide;
    typedef struct packed {
        logic [1:0]  lv;
        logic [11:0] rs1_tag;
        logic [1:0]  rs1_pend;
        logic [11:0] rs2_tag;
        logic [1:0]  rs2_pend;
        logic [11:0] rd_tag;
        logic [1:0]  rd_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb [$];
    exp_t exp_next;
    exp_t dropped;

    tag_issuer_wide_if #(.TAG_W(6), .EMBEDDED(1), .LANES(2)) bus ();

    tag_issuer_wide #(.TAG_W(6), .EMBEDDED(1), .LANES(2), .PREFETCH_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic cmp_out(input exp_t e, input string name);
        check({name, "_valid"},    32'(bus.out_valid),      32'd1);
        check({name, "_lane_vld"}, 32'(bus.out_lane_valid), 32'(e.lv));
        check({name, "_rs1_tag"},  32'(bus.out_rs1_tag),    32'(e.rs1_tag));
        check({name, "_rs1_pend"}, 32'(bus.out_rs1_pend),   32'(e.rs1_pend));
        check({name, "_rs2_tag"},  32'(bus.out_rs2_tag),    32'(e.rs2_tag));
        check({name, "_rs2_pend"}, 32'(bus.out_rs2_pend),   32'(e.rs2_pend));
        check({name, "_rd_tag"},   32'(bus.out_rd_tag),     32'(e.rd_tag));
        check({name, "_rd_valid"}, 32'(bus.out_rd_valid),   32'(e.rd_valid));
    endtask

    function automatic exp_t mk(input logic [1:0] lv, input logic [11:0] t1, input logic [1:0] p1,
                                input logic [11:0] t2, input logic [1:0] p2,
                                input logic [11:0] rt, input logic [1:0] rv);
        exp_t e;
        e.lv = lv; e.rs1_tag = t1; e.rs1_pend = p1; e.rs2_tag = t2; e.rs2_pend = p2;
        e.rd_tag = rt; e.rd_valid = rv;
        return e;
    endfunction

    task automatic clear_lanes();
        bus.in_lane_valid = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.in_rs1_en = '0; bus.in_rs2_en = '0; bus.in_rd_en = '0;
    endtask

    task automatic lane(input int k, input logic lv, input logic [3:0] r1, input logic e1,
                        input logic [3:0] r2, input logic e2, input logic [3:0] rd, input logic erd);
        bus.in_lane_valid[k]  = lv;
        bus.in_rs1[k*4 +: 4]  = r1;
        bus.in_rs1_en[k]      = e1;
        bus.in_rs2[k*4 +: 4]  = r2;
        bus.in_rs2_en[k]      = e2;
        bus.in_rd[k*4 +: 4]   = rd;
        bus.in_rd_en[k]       = erd;
    endtask

    task automatic commit(input logic [3:0] a, input logic [5:0] t);
        bus.commit_valid = 1'b1; bus.commit_addr = a; bus.commit_tag = t;
    endtask

    // Observe handshakes just before the edge, then advance to 1 time unit after it.
    task automatic tick();
        logic acc;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed output with %0d queued, expected 1", sb.size());
            end
            if (sb.size() != 0) cmp_out(sb.pop_front(), "out");
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb.push_back(exp_next);
        @(posedge clk);
        #1;
        bus.pool_valid = 1'b0;
        bus.commit_valid = 1'b0;
        bus.flush = 1'b0;
        if (acc) bus.in_valid = 1'b0;
    endtask

    task automatic push_tag(input logic [5:0] t);
        bus.pool_valid = 1'b1; bus.pool_tag = t;
        tick();
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.pool_valid = 1'b0; bus.pool_tag = '0;
        bus.commit_valid = 1'b0; bus.commit_addr = '0; bus.commit_tag = '0;
        clear_lanes();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  32'(bus.out_valid),    32'd0);
        check("rst_rd_tag",     32'(bus.out_rd_tag),   32'd0);
        check("rst_rd_valid",   32'(bus.out_rd_valid), 32'd0);
        check("rst_pool_ready", 32'(bus.pool_ready),   32'd1);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        push_tag(6'd5); push_tag(6'd6); push_tag(6'd7); push_tag(6'd8);
        check("fifo_full", 32'(bus.pool_ready), 32'd0);

        // Two fresh destinations, oldest tag to lane 0.
        lane(0, 1, 0, 0, 0, 0, 4'd3, 1); lane(1, 1, 0, 0, 0, 0, 4'd4, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, 12'd0, 2'b00, 12'd0, 2'b00, {6'd6, 6'd5}, 2'b11);
        #1; check("A_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("A_latency", 32'(bus.out_valid), 32'd1);

        // Intra-bundle bypass plus table hits; rd=0 takes no tag.
        clear_lanes();
        lane(0, 1, 4'd4, 1, 0, 0, 4'd2, 1); lane(1, 1, 4'd2, 1, 4'd3, 1, 4'd0, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd7, 6'd6}, 2'b11, {6'd5, 6'd0}, 2'b10, {6'd0, 6'd7}, 2'b01);
        #1; check("B_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // One tag left, two needed: stall until the pool delivers.
        clear_lanes();
        lane(0, 1, 0, 0, 0, 0, 4'd10, 1); lane(1, 1, 0, 0, 0, 0, 4'd7, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, 12'd0, 2'b00, 12'd0, 2'b00, {6'd9, 6'd8}, 2'b11);
        #1; check("C_stall_a", 32'(bus.in_ready), 32'd0);
        tick();
        check("C_stall_b", 32'(bus.in_ready), 32'd0);
        bus.pool_valid = 1'b1; bus.pool_tag = 6'd9;
        #1; check("C_stall_push", 32'(bus.in_ready), 32'd0);
        tick();
        check("C_go", 32'(bus.in_ready), 32'd1);
        tick();

        // FIFO empty; disabled lane and rd=0 need nothing.
        clear_lanes();
        lane(0, 0, 0, 0, 0, 0, 4'd5, 1); lane(1, 1, 0, 0, 0, 0, 4'd0, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b10, 12'd0, 2'b00, 12'd0, 2'b00, 12'd0, 2'b00);
        #1; check("Z_no_need", 32'(bus.in_ready), 32'd1);
        tick();

        clear_lanes();
        commit(4'd7, 6'd12);
        tick();
        lane(0, 1, 4'd7, 1, 0, 0, 0, 0); lane(1, 1, 0, 0, 4'd10, 1, 0, 0);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd0, 6'd9}, 2'b01, {6'd8, 6'd0}, 2'b10, 12'd0, 2'b00);
        tick();
        clear_lanes();
        commit(4'd7, 6'd9);
        tick();
        lane(0, 1, 4'd7, 1, 4'd3, 1, 0, 0); lane(1, 1, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd0, 6'd9}, 2'b00, {6'd0, 6'd5}, 2'b01, 12'd0, 2'b00);
        tick();

        clear_lanes();
        push_tag(6'd20); push_tag(6'd21); push_tag(6'd22); push_tag(6'd23);

        // Issue and matching commit to r3 together: the issue write survives.
        lane(0, 1, 0, 0, 0, 0, 4'd3, 1); lane(1, 1, 4'd3, 1, 0, 0, 0, 0);
        commit(4'd3, 6'd5);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        exp_next = mk(2'b11, {6'd20, 6'd0}, 2'b10, 12'd0, 2'b00, {6'd0, 6'd20}, 2'b01);
        #1; check("F_ready", 32'(bus.in_ready), 32'd1);
        tick();

        clear_lanes();
        lane(0, 1, 4'd3, 1, 0, 0, 0, 0); lane(1, 1, 0, 0, 4'd3, 1, 4'd3, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd0, 6'd20}, 2'b01, {6'd20, 6'd0}, 2'b10, {6'd21, 6'd0}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            #1; check("G_blocked", 32'(bus.in_ready), 32'd0);
            cmp_out(sb[0], "hold");
            tick();
        end
        bus.out_ready = 1'b1;
        #1; check("G_same_cycle", 32'(bus.in_ready), 32'd1);
        tick();

        clear_lanes();
        lane(0, 1, 0, 0, 0, 0, 4'd11, 1); lane(1, 1, 4'd11, 1, 0, 0, 4'd11, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd22, 6'd0}, 2'b10, 12'd0, 2'b00, {6'd23, 6'd22}, 2'b11);
        tick();
        clear_lanes();
        lane(0, 1, 4'd11, 1, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b01, {6'd0, 6'd23}, 2'b01, 12'd0, 2'b00, 12'd0, 2'b00);
        tick();

        clear_lanes();
        push_tag(6'd30); push_tag(6'd31);
        lane(0, 1, 4'd3, 1, 0, 0, 0, 0);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        exp_next = mk(2'b01, {6'd0, 6'd21}, 2'b01, 12'd0, 2'b00, 12'd0, 2'b00);
        tick();

        // Flush while a bundle waits and an output is held.
        clear_lanes();
        lane(0, 1, 0, 0, 0, 0, 4'd12, 1);
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        commit(4'd11, 6'd23);
        #1; check("flush_block", 32'(bus.in_ready), 32'd0);
        tick();
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        dropped = sb.pop_front();
        bus.out_ready = 1'b1;

        clear_lanes();
        lane(0, 1, 4'd11, 1, 0, 0, 4'd12, 1); lane(1, 1, 0, 0, 4'd3, 1, 4'd13, 1);
        bus.in_valid = 1'b1;
        exp_next = mk(2'b11, {6'd0, 6'd23}, 2'b00, {6'd21, 6'd0}, 2'b00, {6'd31, 6'd30}, 2'b11);
        #1; check("K_fifo_kept", 32'(bus.in_ready), 32'd1);
        tick();
        clear_lanes();
        lane(0, 1, 0, 0, 0, 0, 4'd14, 1);
        bus.in_valid = 1'b1;
        #1; check("L_fifo_empty", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Asynchronous reset with a held output and a queued tag.
        clear_lanes();
        push_tag(6'd40);
        lane(0, 1, 0, 0, 0, 0, 4'd15, 1);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        exp_next = mk(2'b01, 12'd0, 2'b00, 12'd0, 2'b00, {6'd0, 6'd40}, 2'b01);
        tick();
        check("M_held", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid),  32'd0);
        check("arst_rd_tag",    32'(bus.out_rd_tag), 32'd0);
        check("arst_pool_rdy",  32'(bus.pool_ready), 32'd1);
        dropped = sb.pop_front();
        rst = 1'b0; bus.out_ready = 1'b1;
        clear_lanes();
        lane(0, 1, 0, 0, 0, 0, 4'd1, 1);
        bus.in_valid = 1'b1;
        #1; check("arst_fifo_lost", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
